demux_1_4_stream: RTL and testbench
===================================

# demux_1_4_stream

Registered 1-to-4 stream demultiplexer, the inverse of the 4:1 data mux. It accepts one W-bit word per cycle on a valid/ready upstream port and routes it by `sel` into one of four independent single-entry output slots. Each slot has its own valid/ready downstream port and a wrapping delivered-word counter. It sits where one shared producer fans out to four consumers, so that a stalled consumer blocks only traffic addressed to it.

## Interface
Parameters:
- `W`, default 4: data width of the upstream word and of each downstream word.
- `CW`, default 8: width of each per-output delivered-word counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `up_valid`  in  1  upstream word present.
- `up_data`  in  W  upstream word.
- `up_sel`  in  2  destination index 0..3; qualified by `up_valid`.
- `up_ready`  out  1  combinational accept indication.
- `dn_valid`  out  4  bit i = slot i holds a word.
- `dn_ready`  in  4  bit i = consumer i accepts.
- `y0`, `y1`, `y2`, `y3`  out  W each  slot data, registered.
- `cnt0`, `cnt1`, `cnt2`, `cnt3`  out  CW each  words delivered on output i, modulo 2^CW.

## Operation
- State per slot i: `full[i]`, `data[i]` (W bits), `cnt[i]` (CW bits). `dn_valid[i] = full[i]` and `y_i = data[i]`.
- Upstream accept: `acc = up_valid & up_ready`.
- `up_ready = ~full[up_sel] | dn_ready[up_sel]`. The value is computed even when `up_valid` is 0.
- Downstream handshake: `drain[i] = full[i] & dn_ready[i]`.
- Slot update at the clock edge, evaluated per i:
  - `acc & (up_sel == i)`: `full[i] <= 1`, `data[i] <= up_data`. Load wins over a simultaneous drain, so the slot stays full with the new word.
  - else if `drain[i]`: `full[i] <= 0`. `data[i]` holds its old value.
  - else: hold.
- Counter: `cnt[i] <= cnt[i] + 1` on every `drain[i]`. It wraps from 2^CW-1 to 0 with no saturation and no flag.
- Isolation: a full, unready slot j deasserts `up_ready` only while `up_sel == j`. Traffic to the other slots is unaffected. Upstream holds `up_data` and `up_sel` until accepted; the block does not reorder or drop words.
- Words to the same slot are delivered in acceptance order. No ordering is defined between different slots.
- The block has no state machine beyond the four independent full/empty slot bits.
- `up_sel` is 2 bits and fully decoded, so there is no illegal destination.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-transfer):
  - `full` = 0, `data` = 0, `cnt` = 0 immediately.
  - So `dn_valid` = 4'b0000, `y0..y3` = 0, `cnt0..cnt3` = 0, and `up_ready` = 1.
  - Words held in slots at reset are discarded.
  - Reset deassertion is synchronous to `clk` by upstream convention. The first accept can occur on the first edge after release.
- Latency: a word accepted at edge k appears on `y_i` with `dn_valid[i]` = 1 immediately after edge k, and is visible during cycle k+1.
- Throughput: 1 word per cycle into a slot whose consumer holds `dn_ready[i]` = 1 continuously. Load and drain occur on the same edge.
- Stall: a full slot i with `dn_ready[i]` = 0 holds `y_i` stable. `up_ready` = 0 while `up_sel` = i.
- Combinational paths: `up_sel`→`up_ready` and `dn_ready`→`up_ready`. There are no other combinational input-to-output paths, and `y`, `dn_valid` and `cnt` are pure register outputs.

## Test plan
- Reset check: assert `rst_n` = 0 mid-stream with slot 2 full and `cnt2` = 5 -> `dn_valid` = 0, `y2` = 0, `cnt2` = 0 and `up_ready` = 1, all without waiting for a clock edge.
- Basic routing: send 4'hA→sel 0, 4'h5→sel 1, 4'h3→sel 2, 4'hC→sel 3 on consecutive cycles with all `dn_ready` = 0 -> `dn_valid` = 4'b1111, `y0..y3` = A, 5, 3, C. A fifth word to sel 1 sees `up_ready` = 0 until `dn_ready[1]` rises.
- Back-to-back throughput: 16 consecutive words 0..F to sel 3 with `dn_ready[3]` = 1 -> `up_ready` stays 1, `y3` follows each word with 1 cycle of latency, and `cnt3` = 16.
- Isolation: slot 0 full with `dn_ready[0]` = 0 held -> words to sel 1..3 are accepted every cycle, and `y0` stays unchanged for the whole run.
- Simultaneous load and drain: slot 2 full with 4'h7, then present 4'h9 to sel 2 while `dn_ready[2]` = 1 -> the 7 is delivered, `y2` = 9 on the next cycle, `dn_valid[2]` stays 1, and `cnt2` increments by 1.
- Counter wrap: with `CW` = 8, deliver 257 words to output 1 -> `cnt1` = 1, with no other side effect.

Source files
------------

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer: one upstream valid/ready port feeds four
// single-entry output slots, each with its own valid/ready port and delivery counter.
module demux_1_4_stream #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [W-1:0]  up_data,
  input  logic [1:0]    up_sel,
  output logic          up_ready,
  output logic [3:0]    dn_valid,
  input  logic [3:0]    dn_ready,
  output logic [W-1:0]  y0,
  output logic [W-1:0]  y1,
  output logic [W-1:0]  y2,
  output logic [W-1:0]  y3,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
);

  logic [3:0]    r_full;
  logic [W-1:0]  r_data [4];
  logic [CW-1:0] r_cnt  [4];

  logic          w_acc;
  logic [3:0]    w_load;
  logic [3:0]    w_drain;

  // A slot can take a new word when empty or when its word leaves on this same edge.
  assign up_ready = ~r_full[up_sel] | dn_ready[up_sel];
  assign w_acc    = up_valid & up_ready;
  assign w_load   = {4{w_acc}} & (4'b0001 << up_sel);
  assign w_drain  = r_full & dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        // Load takes priority so a slot refilled while draining stays full.
        if (w_load[i]) begin
          r_full[i] <= 1'b1;
          r_data[i] <= up_data;
        end else if (w_drain[i]) begin
          r_full[i] <= 1'b0;
        end
        if (w_drain[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign dn_valid = r_full;
  assign y0   = r_data[0];
  assign y1   = r_data[1];
  assign y2   = r_data[2];
  assign y3   = r_data[3];
  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Scoreboard bench for demux_1_4_stream: accepted words are queued per slot and
// compared against the slot output when the consumer takes them.
module tb_demux_1_4_stream;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          up_valid;
  logic [W-1:0]  up_data;
  logic [1:0]    up_sel;
  logic          up_ready;
  logic [3:0]    dn_valid;
  logic [3:0]    dn_ready;
  logic [W-1:0]  y   [4];
  logic [CW-1:0] cnt [4];

  demux_1_4_stream #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (up_valid),
    .up_data  (up_data),
    .up_sel   (up_sel),
    .up_ready (up_ready),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .y0       (y[0]),
    .y1       (y[1]),
    .y2       (y[2]),
    .y3       (y[3]),
    .cnt0     (cnt[0]),
    .cnt1     (cnt[1]),
    .cnt2     (cnt[2]),
    .cnt3     (cnt[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]  q [4][$];
  logic [3:0]    m_full;
  logic [CW-1:0] m_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_full = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      m_cnt[i] = '0;
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dn_valid%0d", i), 32'(dn_valid[i]), 32'(m_full[i]));
      chk($sformatf("cnt%0d", i), 32'(cnt[i]), 32'(m_cnt[i]));
      if (m_full[i]) chk($sformatf("y%0d_held", i), 32'(y[i]), 32'(q[i][0]));
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                      input logic [3:0] r);
    logic exp_rdy;
    logic [W-1:0] w;
    up_valid = v;
    up_data  = d;
    up_sel   = s;
    dn_ready = r;
    #2;
    exp_rdy = !m_full[s] || r[s];
    chk("up_ready", 32'(up_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && r[i]) begin
        w = q[i].pop_front();
        chk($sformatf("drain_y%0d", i), 32'(y[i]), 32'(w));
        m_cnt[i] = m_cnt[i] + 1'b1;
        m_full[i] = 1'b0;
      end
    end
    if (v && exp_rdy) begin
      q[s].push_back(d);
      m_full[s] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] y0_hold;

  initial begin
    rst_n    = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    up_sel   = 2'd0;
    dn_ready = 4'b0000;
    model_clear();
    #12;
    chk("rst_dn_valid", 32'(dn_valid), 32'h0);
    chk("rst_up_ready", 32'(up_ready), 32'h1);
    release_reset();

    // Basic routing with all consumers stalled.
    step(1'b1, 4'hA, 2'd0, 4'b0000);
    step(1'b1, 4'h5, 2'd1, 4'b0000);
    step(1'b1, 4'h3, 2'd2, 4'b0000);
    step(1'b1, 4'hC, 2'd3, 4'b0000);
    chk("route_dn_valid", 32'(dn_valid), 32'hF);
    chk("route_y0", 32'(y[0]), 32'hA);
    chk("route_y1", 32'(y[1]), 32'h5);
    chk("route_y2", 32'(y[2]), 32'h3);
    chk("route_y3", 32'(y[3]), 32'hC);
    // Fifth word to slot 1 waits for its consumer.
    for (int k = 0; k < 3; k++) step(1'b1, 4'h6, 2'd1, 4'b0000);
    step(1'b1, 4'h6, 2'd1, 4'b0010);
    chk("fifth_y1", 32'(y[1]), 32'h6);
    step(1'b0, 4'h0, 2'd0, 4'b1111);
    step(1'b0, 4'h0, 2'd0, 4'b1111);

    // Simultaneous load and drain on slot 2.
    step(1'b1, 4'h7, 2'd2, 4'b0000);
    step(1'b1, 4'h9, 2'd2, 4'b0100);
    chk("lddr_y2", 32'(y[2]), 32'h9);
    chk("lddr_valid2", 32'(dn_valid[2]), 32'h1);

    // Isolation: slot 0 stalled while slots 1..3 stream.
    step(1'b1, 4'hE, 2'd0, 4'b0000);
    y0_hold = 4'hE;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, W'(k), 2'(1 + (k % 3)), 4'b1110);
      chk("iso_y0", 32'(y[0]), 32'(y0_hold));
    end
    step(1'b0, 4'h0, 2'd0, 4'b1111);

    // Mid-stream async reset with slot 2 full and cnt2 = 5.
    rst_n = 1'b0;
    #3;
    model_clear();
    release_reset();
    for (int k = 0; k < 6; k++) step(1'b1, W'(k + 1), 2'd2, 4'b0100);
    step(1'b0, 4'h0, 2'd2, 4'b0000);
    chk("pre_rst_cnt2", 32'(cnt[2]), 32'd5);
    up_sel = 2'd2;
    dn_ready = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dn_valid", 32'(dn_valid), 32'h0);
    chk("rst_mid_y2", 32'(y[2]), 32'h0);
    chk("rst_mid_cnt2", 32'(cnt[2]), 32'h0);
    chk("rst_mid_up_ready", 32'(up_ready), 32'h1);
    model_clear();
    release_reset();

    // Back-to-back throughput on slot 3.
    for (int k = 0; k < 16; k++) step(1'b1, W'(k), 2'd3, 4'b1000);
    step(1'b0, 4'h0, 2'd3, 4'b1000);
    chk("tput_cnt3", 32'(cnt[3]), 32'd16);

    // Counter wrap on output 1.
    for (int k = 0; k < 257; k++) step(1'b1, W'($urandom_range(15)), 2'd1, 4'b0010);
    step(1'b0, 4'h0, 2'd1, 4'b0010);
    chk("wrap_cnt1", 32'(cnt[1]), 32'd1);
    chk("wrap_cnt0", 32'(cnt[0]), 32'd0);
    chk("wrap_cnt2", 32'(cnt[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
